// File: rtl/mm_job_sched.sv
// Job scheduler in front of the matrix-multiply controller: queues descriptors,
// launches them one at a time and returns one completion record per job.
module mm_job_sched #(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [ID_W-1:0]            job_id_i,
  input  logic [ADDR_W-1:0]          job_m_i,
  input  logic [ADDR_W-1:0]          job_k_i,
  input  logic [ADDR_W-1:0]          job_n_i,
  input  logic [ADDR_W-1:0]          job_addra_i,
  input  logic [ADDR_W-1:0]          job_addrb_i,
  input  logic [ADDR_W-1:0]          job_addrp_i,
  output logic                       ctrl_start_o,
  input  logic                       ctrl_valid_i,
  output logic [ADDR_W-1:0]          ctrl_m_o,
  output logic [ADDR_W-1:0]          ctrl_k_o,
  output logic [ADDR_W-1:0]          ctrl_n_o,
  output logic [ADDR_W-1:0]          ctrl_addra_o,
  output logic [ADDR_W-1:0]          ctrl_addrb_o,
  output logic [ADDR_W-1:0]          ctrl_addrp_o,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [ID_W-1:0]            done_id_o,
  output logic                       done_err_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic [15:0]                done_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RELEASE, REPORT} state_t;

  logic [ID_W-1:0]   q_id [DEPTH];
  logic [ADDR_W-1:0] q_m  [DEPTH];
  logic [ADDR_W-1:0] q_k  [DEPTH];
  logic [ADDR_W-1:0] q_n  [DEPTH];
  logic [ADDR_W-1:0] q_a  [DEPTH];
  logic [ADDR_W-1:0] q_b  [DEPTH];
  logic [ADDR_W-1:0] q_p  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [15:0]   done_cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          head_zero;

  assign full        = (count == CW'(DEPTH));
  assign push        = job_valid_i && !full;
  assign pop         = (state == IDLE) && (count != '0);
  assign head_zero   = (q_m[rd_ptr] == '0) || (q_k[rd_ptr] == '0) || (q_n[rd_ptr] == '0);

  assign job_ready_o = !full;
  assign pending_o   = count;
  assign busy_o      = (state != IDLE) || (count != '0);
  assign done_cnt_o  = done_cnt;

  // Descriptor storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_id[wr_ptr] <= job_id_i;
      q_m[wr_ptr]  <= job_m_i;
      q_k[wr_ptr]  <= job_k_i;
      q_n[wr_ptr]  <= job_n_i;
      q_a[wr_ptr]  <= job_addra_i;
      q_b[wr_ptr]  <= job_addrb_i;
      q_p[wr_ptr]  <= job_addrp_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control FSM; every controller and completion output is a register here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      ctrl_start_o <= 1'b0;
      ctrl_m_o     <= '0;
      ctrl_k_o     <= '0;
      ctrl_n_o     <= '0;
      ctrl_addra_o <= '0;
      ctrl_addrb_o <= '0;
      ctrl_addrp_o <= '0;
      done_valid_o <= 1'b0;
      done_id_o    <= '0;
      done_err_o   <= 1'b0;
      done_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            ctrl_m_o     <= q_m[rd_ptr];
            ctrl_k_o     <= q_k[rd_ptr];
            ctrl_n_o     <= q_n[rd_ptr];
            ctrl_addra_o <= q_a[rd_ptr];
            ctrl_addrb_o <= q_b[rd_ptr];
            ctrl_addrp_o <= q_p[rd_ptr];
            done_id_o    <= q_id[rd_ptr];
            if (head_zero) begin
              state        <= REPORT;
              done_valid_o <= 1'b1;
              done_err_o   <= 1'b1;
            end else begin
              state        <= LAUNCH;
              ctrl_start_o <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (ctrl_valid_i) begin
            state        <= RELEASE;
            ctrl_start_o <= 1'b0;
          end
        end
        RELEASE: begin
          if (!ctrl_valid_i) begin
            state        <= REPORT;
            done_valid_o <= 1'b1;
            done_err_o   <= 1'b0;
          end
        end
        REPORT: begin
          if (done_ready_i) begin
            state        <= IDLE;
            done_valid_o <= 1'b0;
            done_cnt     <= done_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_sched.sv
// Directed bench for mm_job_sched: transaction-level reference model compared
// every cycle, plus literal expectations for latency, ordering, errors and wrap.
module tb_mm_job_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [3:0]  job_id;
  logic [15:0] job_m, job_k, job_n, job_a, job_b, job_p;
  logic        ctrl_start;
  logic        ctrl_valid;
  logic [15:0] ctrl_m, ctrl_k, ctrl_n, ctrl_a, ctrl_b, ctrl_p;
  logic        done_valid;
  logic        done_ready;
  logic [3:0]  done_id;
  logic        done_err;
  logic        busy;
  logic [2:0]  pending;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  mm_job_sched #(.ADDR_W(16), .ID_W(4), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_id_i(job_id),
    .job_m_i(job_m), .job_k_i(job_k), .job_n_i(job_n),
    .job_addra_i(job_a), .job_addrb_i(job_b), .job_addrp_i(job_p),
    .ctrl_start_o(ctrl_start), .ctrl_valid_i(ctrl_valid),
    .ctrl_m_o(ctrl_m), .ctrl_k_o(ctrl_k), .ctrl_n_o(ctrl_n),
    .ctrl_addra_o(ctrl_a), .ctrl_addrb_o(ctrl_b), .ctrl_addrp_o(ctrl_p),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .done_id_o(done_id), .done_err_o(done_err),
    .busy_o(busy), .pending_o(pending), .done_cnt_o(done_cnt)
  );

  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic prev_start = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a job queue plus the job currently owned by the block.
  typedef struct {
    logic [3:0]  id;
    logic [15:0] m, k, n, a, b, p;
  } job_t;

  job_t        mq[$];
  job_t        cur;
  job_t        nj;
  int          mph;   // 0 waiting, 1 start asserted, 2 start dropped, 3 record offered
  logic [15:0] m_cnt;
  bit          acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cur   = '{default: '0};
      mph   = 0;
      m_cnt = '0;
    end else begin
      acc = job_valid && (mq.size() < DEPTH);
      nj  = '{job_id, job_m, job_k, job_n, job_a, job_b, job_p};
      case (mph)
        0: if (mq.size() > 0) begin
             cur = mq.pop_front();
             mph = (cur.m == 0 || cur.k == 0 || cur.n == 0) ? 3 : 1;
           end
        1: if (ctrl_valid) mph = 2;
        2: if (!ctrl_valid) mph = 3;
        default: if (done_ready) begin mph = 0; m_cnt = m_cnt + 16'd1; end
      endcase
      if (acc) mq.push_back(nj);
    end
  end

  always @(negedge clk) begin
    chk("ready",      32'(job_ready),  32'(mq.size() < DEPTH));
    chk("pending",    32'(pending),    32'(mq.size()));
    chk("busy",       32'(busy),       32'(mph != 0 || mq.size() != 0));
    chk("start",      32'(ctrl_start), 32'(mph == 1));
    chk("done_valid", 32'(done_valid), 32'(mph == 3));
    chk("ctrl_m",     32'(ctrl_m),     32'(cur.m));
    chk("ctrl_k",     32'(ctrl_k),     32'(cur.k));
    chk("ctrl_n",     32'(ctrl_n),     32'(cur.n));
    chk("ctrl_a",     32'(ctrl_a),     32'(cur.a));
    chk("ctrl_b",     32'(ctrl_b),     32'(cur.b));
    chk("ctrl_p",     32'(ctrl_p),     32'(cur.p));
    chk("done_cnt",   32'(done_cnt),   32'(m_cnt));
    if (mph == 3) begin
      chk("done_id",  32'(done_id),    32'(cur.id));
      chk("done_err", 32'(done_err),   32'(cur.m == 0 || cur.k == 0 || cur.n == 0));
    end
    if (ctrl_start && !prev_start) rises++;
    prev_start = ctrl_start;
  end

  // Controller stand-in: valid 3 cycles after start, dropped 2 cycles after start falls.
  int rc = 0;
  initial begin
    ctrl_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ctrl_valid = 1'b0;
        rc = 0;
      end else if (ctrl_start && !ctrl_valid) begin
        rc++;
        if (rc >= 3) begin ctrl_valid = 1'b1; rc = 0; end
      end else if (!ctrl_start && ctrl_valid) begin
        rc++;
        if (rc >= 2) begin ctrl_valid = 1'b0; rc = 0; end
      end
    end
  end

  task automatic push(input logic [3:0] id, input logic [15:0] m, input logic [15:0] k,
                      input logic [15:0] n, input logic [15:0] base);
    bit r = 1'b0;
    job_id = id; job_m = m; job_k = k; job_n = n;
    job_a = base; job_b = base + 16'h100; job_p = base + 16'h200;
    job_valid = 1'b1;
    for (int t = 0; t < 200 && !r; t++) begin
      @(negedge clk);
      r = job_ready;
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
    if (!r) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output logic [3:0] id, output logic err);
    bit found = 1'b0;
    id = '0; err = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (done_valid) begin found = 1'b1; id = done_id; err = done_err; end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  logic [3:0] gid;
  logic       gerr;
  int         r0;

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; done_ready = 1'b1;
    job_id = '0; job_m = '0; job_k = '0; job_n = '0; job_a = '0; job_b = '0; job_p = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(job_ready), 32'd1);
    chk("rst_cnt",   32'(done_cnt),  32'd0);
    @(posedge clk); #1;

    // Single job: start two cycles after acceptance, then one clean completion.
    push(4'd3, 16'd10, 16'd10, 16'd10, 16'h1000);
    @(negedge clk);
    chk("t1_start_c1", 32'(ctrl_start), 32'd0);
    @(negedge clk);
    chk("t1_start_c2", 32'(ctrl_start), 32'd1);
    chk("t1_ctrl_m",   32'(ctrl_m),     32'd10);
    chk("t1_ctrl_b",   32'(ctrl_b),     32'h1100);
    @(posedge clk); #1;
    wait_done(gid, gerr);
    chk("t1_id",  32'(gid),  32'd3);
    chk("t1_err", 32'(gerr), 32'd0);
    @(negedge clk);
    chk("t1_cnt", 32'(done_cnt), 32'd1);
    @(posedge clk); #1;

    // Fill: four queued plus one in flight, completion held back.
    done_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(4'(i), 16'(i + 1), 16'(2 * i + 1), 16'd4, 16'(16'h2000 + 16'(i) * 16'h10));
    job_valid = 1'b1; job_id = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_full_ready", 32'(job_ready), 32'd0);
      chk("t2_full_pend",  32'(pending),   32'd4);
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2_hold_valid", 32'(done_valid), 32'd1);
    chk("t2_hold_id",    32'(done_id),    32'd0);
    chk("t2_hold_start", 32'(ctrl_start), 32'd0);
    chk("t2_hold_busy",  32'(busy),       32'd1);
    @(posedge clk); #1;
    done_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_done(gid, gerr);
      chk("t2_order_id",  32'(gid),  32'(i));
      chk("t2_order_err", 32'(gerr), 32'd0);
    end
    chk("t2_cnt", 32'(done_cnt), 32'd6);

    // Zero-dimension job is retired with error and never launched.
    r0 = rises;
    push(4'd7, 16'd5, 16'd0, 16'd5, 16'h3000);
    push(4'd8, 16'd2, 16'd3, 16'd1, 16'h4000);
    wait_done(gid, gerr);
    chk("t3_id7",  32'(gid),  32'd7);
    chk("t3_err7", 32'(gerr), 32'd1);
    wait_done(gid, gerr);
    chk("t3_id8",  32'(gid),  32'd8);
    chk("t3_err8", 32'(gerr), 32'd0);
    chk("t3_rises", 32'(rises - r0), 32'd1);

    // Reset while launching with two queued.
    push(4'd1, 16'd1, 16'd1, 16'd1, 16'h5000);
    push(4'd2, 16'd1, 16'd1, 16'd1, 16'h5100);
    push(4'd4, 16'd1, 16'd1, 16'd1, 16'h5200);
    chk("t4_pre_start", 32'(ctrl_start), 32'd1);
    chk("t4_pre_pend",  32'(pending),    32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_start", 32'(ctrl_start), 32'd0);
    chk("t4_rst_pend",  32'(pending),    32'd0);
    chk("t4_rst_busy",  32'(busy),       32'd0);
    chk("t4_rst_done",  32'(done_valid), 32'd0);
    chk("t4_rst_ready", 32'(job_ready),  32'd1);
    r0 = rises;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_no_stale", 32'(rises - r0), 32'd0);
    chk("t4_idle",     32'(busy),       32'd0);
    @(posedge clk); #1;

    // Completion counter wrap.
    force dut.done_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1 release dut.done_cnt;
    push(4'd5, 16'd0, 16'd1, 16'd1, 16'h6000);
    push(4'd6, 16'd1, 16'd1, 16'd0, 16'h6100);
    wait_done(gid, gerr);
    chk("t5_err5", 32'(gerr), 32'd1);
    @(negedge clk);
    chk("t5_cnt_ffff", 32'(done_cnt), 32'hFFFF);
    wait_done(gid, gerr);
    chk("t5_id6", 32'(gid), 32'd6);
    @(negedge clk);
    chk("t5_cnt_wrap", 32'(done_cnt), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
